vga_frame_crc: RTL

Self-checking sink for the VGA pixel stream, placed directly downstream of the memory-interfacing stage in parallel with the DAC outputs. It consumes the pipeline-aligned R/G/B bytes, the matching delayed active-video qualifier and vsync. Per frame it accumulates a CRC-32 over all active pixels and checks the line and pixel geometry. At each frame boundary it publishes a one-cycle result strobe. Benches and on-chip debug compare this result instead of dumping 786,432 pixels to a file.

---
 rtl/vga_frame_crc.sv | 82 ++++++++
 1 files changed

// File: rtl/vga_frame_crc.sv
// vga_frame_crc: per-frame CRC-32 and line/pixel geometry check of the aligned VGA pixel stream
module vga_frame_crc #(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  R,
  input  logic [7:0]  G,
  input  logic [7:0]  B,
  input  logic        active_video_d,
  input  logic        vsync,
  output logic [31:0] frame_crc,
  output logic        frame_ok,
  output logic        frame_valid,
  output logic [15:0] frame_count
);
  localparam int PW = $clog2(H_ACTIVE + 1) + 1;
  localparam int LW = $clog2(V_ACTIVE + 1) + 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic vs_q, av_q, geom_err;
  logic [31:0] crc;
  logic [PW-1:0] pix_cnt;
  logic [LW-1:0] line_cnt;
  logic vs_edge, line_end, open_line, close_err;
  logic [31:0] crc_next;
  logic [PW-1:0] pix_next;
  logic [LW-1:0] line_inc, close_lines;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) x = x[0] ? (x >> 1) ^ 32'hEDB88320 : x >> 1;
    return x;
  endfunction
  always_comb begin
    vs_edge     = (vsync ^ VSYNC_ACTIVE_LOW) & ~(vs_q ^ VSYNC_ACTIVE_LOW);
    line_end    = av_q & ~active_video_d;
    crc_next    = active_video_d ? crc_byte(crc_byte(crc_byte(crc, R), G), B) : crc;
    pix_next    = active_video_d && !(&pix_cnt) ? pix_cnt + PW'(1) : pix_cnt;
    line_inc    = &line_cnt ? line_cnt : line_cnt + LW'(1);
    // a line still open at frame close counts, including the pixel on the edge cycle
    open_line   = active_video_d | av_q;
    close_lines = open_line ? line_inc : line_cnt;
    close_err   = geom_err | (open_line & (pix_next != PW'(H_ACTIVE)));
  end
  always_ff @(posedge clk) begin
    vs_q        <= vsync;
    av_q        <= active_video_d;
    frame_valid <= 1'b0;
    if (reset) begin
      state       <= IDLE;
      crc         <= 32'hFFFFFFFF;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      geom_err    <= 1'b0;
      frame_crc   <= '0;
      frame_ok    <= 1'b0;
      frame_count <= '0;
    end else if (vs_edge) begin
      if (state == RUN) begin
        frame_crc   <= ~crc_next;
        frame_ok    <= !close_err && close_lines == LW'(V_ACTIVE);
        frame_count <= frame_count + 16'd1;
        frame_valid <= 1'b1;
      end
      state    <= RUN;
      crc      <= 32'hFFFFFFFF;
      pix_cnt  <= '0;
      line_cnt <= '0;
      geom_err <= 1'b0;
    end else if (state == RUN) begin
      crc     <= crc_next;
      pix_cnt <= line_end ? '0 : pix_next;
      if (line_end) begin
        line_cnt <= line_inc;
        if (pix_cnt != PW'(H_ACTIVE)) geom_err <= 1'b1;
      end
    end
  end
endmodule
